// File: rtl/spi_ram_engine.sv
// Command-decoded single-port RAM behind the SPI slave: 2-bit opcode words set
// addresses, write data, or issue registered reads returned via ready/valid.
module spi_ram_engine #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              addr_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [1:0] OP_SET_WA = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_SET_RA = 2'b10;
  localparam logic [1:0] OP_RD     = 2'b11;

  // One extra bit so the depth itself (up to 2**ADDR_W) is representable.
  localparam logic [DATA_W:0]   DEPTH = (DATA_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] pay;
  } cmd_t;

  cmd_t              cmd;
  logic [0:0]        state;
  logic [ADDR_W-1:0] addr_wr;
  logic [ADDR_W-1:0] addr_rd;
  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign cmd      = din;
  assign rx_ready = (state == ST_IDLE);
  assign accept   = rx_valid && rx_ready;
  // Full-payload compare: any upper bit beyond the depth counts as out of range.
  assign in_range = ({1'b0, cmd.pay} < DEPTH);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (AUTO_INC == 0) return a;
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  // Storage is deliberately unreset.
  always_ff @(posedge clk) begin
    if (accept && cmd.op == OP_WR) mem[addr_wr] <= cmd.pay;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_wr  <= '0;
      addr_rd  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            case (cmd.op)
              OP_SET_WA: begin
                if (in_range) addr_wr <= cmd.pay[ADDR_W-1:0];
                else          addr_err <= 1'b1;
              end
              OP_WR: addr_wr <= next_addr(addr_wr);
              OP_SET_RA: begin
                if (in_range) addr_rd <= cmd.pay[ADDR_W-1:0];
                else          addr_err <= 1'b1;
              end
              OP_RD: begin
                dout     <= mem[addr_rd];
                tx_valid <= 1'b1;
                addr_rd  <= next_addr(addr_rd);
                state    <= ST_HOLD;
              end
              default: ;
            endcase
          end
        end
        ST_HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_engine.sv
// Bench for spi_ram_engine: three parameterisations side by side, a behavioural
// model checked every cycle, plus directed reads with literal expectations.
module tb_spi_ram_engine;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] din [NI];
  logic        rx_valid [NI];
  logic        tx_ready [NI];
  logic        rx_ready [NI];
  logic        tx_valid [NI];
  logic        addr_err [NI];
  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;

  int checks = 0;
  int errors = 0;

  spi_ram_engine u0 (
    .clk(clk), .rst_n(rst_n), .din(din[0][9:0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .dout(dout0), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .addr_err(addr_err[0]));

  spi_ram_engine #(.MEM_DEPTH(200)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din[1][9:0]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .dout(dout1), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .addr_err(addr_err[1]));

  spi_ram_engine #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .rx_valid(rx_valid[2]),
    .rx_ready(rx_ready[2]), .dout(dout2), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .addr_err(addr_err[2]));

  function automatic int dw(int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic int dep(int k);
    return (k == 0) ? 256 : (k == 1) ? 200 : 1024;
  endfunction

  function automatic int get_dout(int k);
    case (k)
      0:       return int'(dout0);
      1:       return int'(dout1);
      default: return int'(dout2);
    endcase
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: words and addresses as plain ints, modulo wrap.
  int m_tv [NI], m_dout [NI], m_dk [NI], m_err [NI], m_wa [NI], m_ra [NI];
  int mem_m [NI][1024];
  bit known [NI][1024];

  always @(posedge clk or negedge rst_n) begin
    int op, pay;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_tv[k] = 0; m_dout[k] = 0; m_dk[k] = 1; m_err[k] = 0; m_wa[k] = 0; m_ra[k] = 0;
      end else begin
        m_err[k] = 0;
        if (m_tv[k] != 0) begin
          if (tx_ready[k]) m_tv[k] = 0;
        end else if (rx_valid[k]) begin
          op  = int'(din[k]) >> dw(k);
          pay = int'(din[k]) & ((1 << dw(k)) - 1);
          case (op)
            0: if (pay < dep(k)) m_wa[k] = pay; else m_err[k] = 1;
            1: begin
              mem_m[k][m_wa[k]] = pay;
              known[k][m_wa[k]] = 1'b1;
              m_wa[k] = (m_wa[k] + 1) % dep(k);
            end
            2: if (pay < dep(k)) m_ra[k] = pay; else m_err[k] = 1;
            default: begin
              m_dk[k]   = known[k][m_ra[k]] ? 1 : 0;
              m_dout[k] = mem_m[k][m_ra[k]];
              m_tv[k]   = 1;
              m_ra[k]   = (m_ra[k] + 1) % dep(k);
            end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        chk("m_tx_valid", k, int'(tx_valid[k]), m_tv[k]);
        chk("m_rx_ready", k, int'(rx_ready[k]), (m_tv[k] == 0) ? 1 : 0);
        chk("m_addr_err", k, int'(addr_err[k]), m_err[k]);
        if (m_tv[k] != 0 && m_dk[k] != 0) chk("m_dout", k, get_dout(k), m_dout[k]);
      end
    end
  end

  // Drive a command and hold it until the engine accepts it (bounded).
  task automatic send(int k, int op, int pay);
    bit ok = 1'b0;
    din[k] = 18'((op << dw(k)) | pay);
    rx_valid[k] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready[k]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", k, 0, 1);
    @(posedge clk); #1;
    rx_valid[k] = 1'b0;
  endtask

  task automatic rd(int k, int exp);
    send(k, 3, 0);
    chk("rd_valid", k, int'(tx_valid[k]), 1);
    chk("rd_data", k, get_dout(k), exp);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      din[k] = '0; rx_valid[k] = 1'b0; tx_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_tx_valid", k, int'(tx_valid[k]), 0);
      chk("rst_dout", k, get_dout(k), 0);
      chk("rst_addr_err", k, int'(addr_err[k]), 0);
      chk("rst_rx_ready", k, int'(rx_ready[k]), 1);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write / read-back, one-cycle valid with tx_ready tied high
    send(0, 0, 'h10); send(0, 1, 'hA5); send(0, 2, 'h10);
    rd(0, 'hA5);
    chk("t1_rx_ready_low", 0, int'(rx_ready[0]), 0);
    @(posedge clk); #1;
    chk("t1_tx_valid_drop", 0, int'(tx_valid[0]), 0);
    chk("t1_rx_ready_back", 0, int'(rx_ready[0]), 1);

    // Auto-increment across the top of the address space
    send(0, 0, 'hFE); send(0, 1, 'h11); send(0, 1, 'h22); send(0, 1, 'h33);
    send(0, 2, 'hFE);
    rd(0, 'h11); rd(0, 'h22); rd(0, 'h33);
    send(0, 2, 'h00);
    rd(0, 'h33);

    // Back-pressure with a write command waiting behind the read
    send(0, 0, 5); send(0, 1, 'h5A); send(0, 2, 5);
    tx_ready[0] = 1'b0;
    send(0, 3, 0);
    din[0] = 18'((1 << 8) | 'h77);
    rx_valid[0] = 1'b1;
    repeat (5) begin
      chk("t3_hold_valid", 0, int'(tx_valid[0]), 1);
      chk("t3_hold_dout", 0, get_dout(0), 'h5A);
      chk("t3_hold_rx_ready", 0, int'(rx_ready[0]), 0);
      @(posedge clk); #1;
    end
    tx_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("t3_xfer_done", 0, int'(tx_valid[0]), 0);
    @(posedge clk); #1;
    rx_valid[0] = 1'b0;
    send(0, 1, 'h88);
    send(0, 2, 6);
    rd(0, 'h77); rd(0, 'h88);

    // Non-power-of-two depth: range errors and wrap at 199
    send(1, 0, 'h10); send(1, 0, 'hC8);
    chk("t4_err_pulse", 1, int'(addr_err[1]), 1);
    @(posedge clk); #1;
    chk("t4_err_clear", 1, int'(addr_err[1]), 0);
    send(1, 1, 'h3C); send(1, 2, 'h10);
    rd(1, 'h3C);
    send(1, 2, 'hFF); send(1, 2, 'hC8);
    send(1, 0, 'hC7); send(1, 1, 'hAA); send(1, 1, 'hBB);
    send(1, 2, 'hC7);
    rd(1, 'hAA); rd(1, 'hBB);

    // Wide data/address, wrap at 0x3FF, upper payload bit out of range
    send(2, 0, 'h3FF); send(2, 1, 'hBEEF); send(2, 1, 'h1234);
    send(2, 2, 'h3FF);
    rd(2, 'hBEEF); rd(2, 'h1234);
    send(2, 0, 'h8001);
    chk("t5_err_upper", 2, int'(addr_err[2]), 1);

    // Reset in the middle of a held read
    tx_ready[0] = 1'b0;
    send(0, 2, 5);
    send(0, 3, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx_valid", 0, int'(tx_valid[0]), 0);
    chk("t6_rst_dout", 0, get_dout(0), 0);
    @(negedge clk); rst_n = 1'b1;
    tx_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("t6_rx_ready", 0, int'(rx_ready[0]), 1);
    rd(0, 'h33);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_engine.md
# spi_ram_engine

Parametrised command-decoded single-port RAM behind the SPI slave. Upstream delivers 2-bit-opcode command words. The engine supports:
- write/read address setup,
- writes with optional address auto-increment,
- registered reads returned through a ready/valid handshake that back-pressures the command stream.

It generalises the fixed 8-bit/256-entry RAM to arbitrary data width, address width and depth, and adds address range checking.

## Interface
- DATA_W, 8, data word width; command payload width.
- ADDR_W, 8, address register width; must satisfy ADDR_W <= DATA_W.
- MEM_DEPTH, 256, number of words; must satisfy 2 <= MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1, when 1, write address increments after each data write and read address increments after each read.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] opcode, din[DATA_W-1:0] payload.
- rx_valid  in  1  din valid this cycle.
- rx_ready  out  1  engine can accept a command; combinational from state (high in IDLE only).
- dout  out  DATA_W  read data, registered.
- tx_valid  out  1  dout valid, registered.
- tx_ready  in  1  consumer takes dout this cycle.
- addr_err  out  1  one-cycle pulse: address-setup payload out of range.

## Operation
- Command accepted on a rising edge where rx_valid && rx_ready. Nothing happens on an edge without acceptance.
- Opcode 00, set write address:
  - If payload < MEM_DEPTH: addr_wr <= payload[ADDR_W-1:0].
  - Otherwise addr_wr is unchanged and addr_err pulses.
- Opcode 01, write data: mem[addr_wr] <= payload. If AUTO_INC, addr_wr <= addr_wr+1, wrapping MEM_DEPTH-1 -> 0.
- Opcode 10, set read address: same range rule as 00, applied to addr_rd.
- Opcode 11, read:
  - dout <= mem[addr_rd] and tx_valid <= 1; state -> HOLD.
  - If AUTO_INC, addr_rd increments with the same wrap as writes.
  - Payload is ignored.
- Payload bits above ADDR_W count in the range check. Any nonzero upper bit means out of range.
- Two-state FSM:
  - IDLE: rx_ready=1. Opcode 11 accepted -> HOLD. All other opcodes stay in IDLE.
  - HOLD: rx_ready=0. dout and tx_valid are held stable. On an edge with tx_ready=1: tx_valid <= 0, state -> IDLE.
- Memory has no reset. A read of a never-written word returns undefined data.
- Reset values: dout=0, tx_valid=0, addr_err=0, addr_wr=0, addr_rd=0, state=IDLE.

## Timing
- Write latency: a write accepted at edge N is visible to a read accepted at edge N+1.
- Read latency: read accepted at edge N gives dout/tx_valid valid after edge N, i.e. 1 cycle.
- Handshake: a transfer completes on the edge where tx_valid && tx_ready. rx_ready goes high right after that edge.
- Next command is accepted at the earliest on the edge after the transfer edge. With tx_ready tied high, reads sustain one every 2 cycles.
- While in HOLD, rx_valid is ignored. Upstream must hold din/rx_valid until rx_ready.
- tx_ready while tx_valid=0 has no effect.
- addr_err is high for exactly the cycle after the offending edge and low otherwise. Back-to-back bad setups give back-to-back pulses.
- Reset asserted mid-HOLD: pending read is discarded and tx_valid drops immediately (asynchronous). Addresses return to 0.
- Address wrap: increment from MEM_DEPTH-1 gives 0, including when MEM_DEPTH is not a power of two.

## Test plan
1. Default params: cmds 00/0x10, 01/0xA5, 10/0x10, 11 with tx_ready=1 -> dout=0xA5, tx_valid high for exactly 1 cycle, rx_ready low that cycle.
2. AUTO_INC=1: set waddr 0xFE, write 0x11, 0x22, 0x33; set raddr 0xFE; read 3 times -> 0x11, 0x22, 0x33. The third word is at address 0x00 (wrap).
3. Back-pressure: read with tx_ready=0 for 5 cycles while rx_valid=1 carries a 01 command -> dout stable, tx_valid high 5+ cycles. The write is not performed until after the transfer; memory is checked afterwards.
4. MEM_DEPTH=200, ADDR_W=8: set waddr 0xC8 -> addr_err pulses 1 cycle and addr_wr keeps its old value. Set waddr 0xC7, write twice -> second write lands at address 0.
5. DATA_W=16, ADDR_W=10, MEM_DEPTH=1024: write 0xBEEF at 0x3FF, read back -> dout=0xBEEF.
6. Assert rst_n low mid-HOLD -> tx_valid=0, dout=0 immediately. After release, rx_ready=1 and a read returns mem[0].
